// File: rtl/dso_pkg.sv
// Package for the DSO trigger/capture block.
// Holds the capture state encoding, the sample width, the slope selector
// values and the level-crossing helper used by the trigger comparator.
package dso_pkg;

    localparam int SAMPLE_W = 8;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_e;

    // True when the step prev -> cur crosses level in the selected direction.
    function automatic logic level_cross(
        input logic                slope,
        input logic [SAMPLE_W-1:0] prev,
        input logic [SAMPLE_W-1:0] cur,
        input logic [SAMPLE_W-1:0] level
    );
        if (slope == SLOPE_RISE) begin
            return (prev < level) && (cur >= level);
        end
        return (prev >= level) && (cur < level);
    endfunction

endpackage

// File: rtl/dso_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Contents are not reset, so the array maps onto block RAM.
// Ports:
//   clk_i    clock
//   we_i     write enable; wdata_i written to waddr_i
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable; mem[raddr_i] appears on rdata_o next cycle
//   raddr_i  read address
//   rdata_o  registered read data
module dso_sample_ram
    import dso_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [SAMPLE_W-1:0] wdata_i,
    input  logic                re_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [SAMPLE_W-1:0] rdata_o
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [SAMPLE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dso_trigger_capture.sv
// DSO trigger and capture: consumes latched 8-bit ADC samples, drives the
// latch output enable, detects a level/slope (or forced) trigger, keeps a
// circular pre/post-trigger record and replays it oldest-first.
// Ports:
//   CLK         system clock (shared with the sample latch)
//   CLRN        asynchronous active-low reset
//   ARM         pulse: start a capture (accepted in IDLE and DONE)
//   FORCE       pulse: force a trigger while ARMED
//   TRIG_LEVEL  unsigned trigger threshold
//   TRIG_SLOPE  0 = rising, 1 = falling
//   PRE_CNT     pre-trigger sample count, captured on ARM
//   SAMPLE_EN   Q holds a new sample this cycle
//   Q           latched sample bus
//   ONE         latch output enable, active low (low while capturing)
//   BUSY        capture in progress
//   TRIGGERED   trigger seen in current capture
//   DONE        record complete, readout pending
//   RD_REQ      request next record sample
//   RD_DATA     record sample (zero when RD_VALID is low)
//   RD_VALID    RD_DATA valid, one cycle after RD_REQ
//   RD_LAST     final sample of the record
module dso_trigger_capture
    import dso_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                CLK,
    input  logic                CLRN,
    input  logic                ARM,
    input  logic                FORCE,
    input  logic [SAMPLE_W-1:0] TRIG_LEVEL,
    input  logic                TRIG_SLOPE,
    input  logic [AW-1:0]       PRE_CNT,
    input  logic                SAMPLE_EN,
    input  logic [SAMPLE_W-1:0] Q,
    output logic                ONE,
    output logic                BUSY,
    output logic                TRIGGERED,
    output logic                DONE,
    input  logic                RD_REQ,
    output logic [SAMPLE_W-1:0] RD_DATA,
    output logic                RD_VALID,
    output logic                RD_LAST
);

    state_e              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       pre_q, pre_d;
    logic [AW-1:0]       rd_cnt_q, rd_cnt_d;
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic                force_q, force_d;
    logic                trig_q, trig_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;

    logic                capturing;
    logic                we;
    logic                re;
    logic                hit;
    logic [SAMPLE_W-1:0] ram_rdata;

    assign capturing = (state_q == ST_PREFILL) || (state_q == ST_ARMED) ||
                       (state_q == ST_POST);
    assign we        = SAMPLE_EN && capturing;

    // Level trigger needs a valid previous sample; FORCE may arrive on the
    // same cycle as the sample it applies to.
    assign hit = (prev_vld_q && level_cross(TRIG_SLOPE, prev_q, Q, TRIG_LEVEL)) ||
                 force_q || FORCE;

    dso_sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (Q),
        .re_i    (re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        rd_cnt_d   = rd_cnt_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        force_d    = force_q;
        trig_d     = trig_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        re         = 1'b0;

        if (we) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prev_d     = Q;
            prev_vld_d = 1'b1;
        end

        case (state_q)
            ST_PREFILL: begin
                if (we) begin
                    if (cnt_q == pre_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (FORCE) begin
                    force_d = 1'b1;
                end
                if (we) begin
                    force_d = 1'b0;
                    if (hit) begin
                        trig_d   = 1'b1;
                        // Oldest record sample sits pre writes behind the trigger.
                        rd_ptr_d = wr_ptr_q - pre_q;
                        cnt_d    = '0;
                        // pre == DEPTH-1 leaves no post-trigger samples to take.
                        state_d  = (pre_q == '1) ? ST_DONE : ST_POST;
                    end
                end
            end
            ST_POST: begin
                // Post-trigger count is DEPTH-1-pre, i.e. ~pre in AW bits.
                if (we) begin
                    if (cnt_q == ~pre_q - 1'b1) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!ARM && RD_REQ) begin
                    re         = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                    rd_valid_d = 1'b1;
                    if (rd_cnt_q == '1) begin
                        rd_last_d = 1'b1;
                        trig_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase

        // ARM in IDLE starts a capture; ARM in DONE abandons the readout.
        if (ARM && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            // PRE_CNT is AW bits wide, so it never exceeds DEPTH-1.
            pre_d      = PRE_CNT;
            cnt_d      = '0;
            rd_cnt_d   = '0;
            prev_vld_d = 1'b0;
            force_d    = 1'b0;
            trig_d     = 1'b0;
            state_d    = (PRE_CNT == '0) ? ST_ARMED : ST_PREFILL;
        end
    end

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            rd_cnt_q   <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            force_q    <= 1'b0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            rd_cnt_q   <= rd_cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            force_q    <= force_d;
            trig_q     <= trig_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign ONE       = !capturing;
    assign BUSY      = capturing;
    assign TRIGGERED = trig_q;
    assign DONE      = (state_q == ST_DONE);
    assign RD_VALID  = rd_valid_q;
    assign RD_LAST   = rd_last_q;
    // RAM output register has no reset; gate it so RD_DATA reads 0 after reset.
    assign RD_DATA   = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dso_trigger_capture.sv
module tb_dso_trigger_capture;

    logic       CLK = 1'b0;
    logic       CLRN = 1'b0;
    logic       ARM = 1'b0;
    logic       FORCE = 1'b0;
    logic [7:0] TRIG_LEVEL = 8'h80;
    logic       TRIG_SLOPE = 1'b0;
    logic [3:0] PRE_CNT = 4'd0;
    logic       SAMPLE_EN = 1'b0;
    logic [7:0] Q = 8'hFF;
    logic       ONE, BUSY, TRIGGERED, DONE;
    logic       RD_REQ = 1'b0;
    logic [7:0] RD_DATA;
    logic       RD_VALID, RD_LAST;

    int checks = 0;
    int failures = 0;
    int k_g = 0;
    logic [8:0] sb_q[$];

    dso_trigger_capture #(.DEPTH(16), .AW(4)) dut (
        .CLK(CLK), .CLRN(CLRN), .ARM(ARM), .FORCE(FORCE),
        .TRIG_LEVEL(TRIG_LEVEL), .TRIG_SLOPE(TRIG_SLOPE), .PRE_CNT(PRE_CNT),
        .SAMPLE_EN(SAMPLE_EN), .Q(Q), .ONE(ONE), .BUSY(BUSY),
        .TRIGGERED(TRIGGERED), .DONE(DONE), .RD_REQ(RD_REQ),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_LAST(RD_LAST)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sample stream per stimulus id.
    function automatic logic [7:0] qfun(input int qid, input int k);
        case (qid)
            1: return 8'(k * 16);
            2: return 8'(8'h60 + k);
            3: return 8'(8'h90 + k * 16);
            default: return (k == 54) ? 8'hC0 : 8'(k);
        endcase
    endfunction

    // Hand-derived record contents, oldest first.
    function automatic logic [7:0] exp_rec(input int eid, input int i);
        case (eid)
            1: return 8'(8'h40 + 16 * i);   // pre=4, trigger 0x80 on ramp
            2: return 8'(8'h84 + i);        // forced trigger at 0x88
            3: return 8'(8'h80 + 16 * i);   // pre=0, trigger first
            4: return 8'(8'h90 + 16 * i);   // pre=15, trigger last
            default: return (i == 4) ? 8'hC0 : 8'(50 + i);  // gapped, wrap
        endcase
    endfunction

    always @(negedge CLK) begin
        if (RD_VALID === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected actual=%0h required=no_valid", {RD_LAST, RD_DATA});
            end else begin
                logic [8:0] e;
                e = sb_q.pop_front();
                if ({RD_LAST, RD_DATA} !== e) begin
                    failures++;
                    $display("FAIL rd_data actual=%0h required=%0h", {RD_LAST, RD_DATA}, e);
                end
            end
        end
    end

    task automatic arm(input logic [3:0] pre, input logic slope, input logic [7:0] lvl);
        @(negedge CLK);
        ARM = 1'b1; PRE_CNT = pre; TRIG_SLOPE = slope; TRIG_LEVEL = lvl;
        @(negedge CLK);
        ARM = 1'b0;
        check("arm_one", ONE, 0);
        check("arm_busy", BUSY, 1);
        k_g = 0;
    endtask

    task automatic feed(input int qid, input int n, input int gap, input bit stop);
        bit broke;
        broke = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge CLK);
            if (stop && DONE) begin
                broke = 1;
                break;
            end
            SAMPLE_EN = 1'b1;
            Q = qfun(qid, k_g);
            k_g++;
            for (int g = 0; g < gap; g++) begin
                @(negedge CLK);
                SAMPLE_EN = 1'b0;
                Q = 8'hFF;
            end
        end
        if (!broke && SAMPLE_EN) @(negedge CLK);
        SAMPLE_EN = 1'b0;
        Q = 8'hFF;
    endtask

    task automatic capture_done(input int qid, input int gap);
        feed(qid, 200, gap, 1'b1);
        check("done", DONE, 1);
        check("done_one", ONE, 1);
        check("done_busy", BUSY, 0);
        check("done_trig", TRIGGERED, 1);
    endtask

    task automatic read_all(input int eid, input int ncyc);
        for (int i = 0; i < 16; i++) sb_q.push_back({(i == 15), exp_rec(eid, i)});
        @(negedge CLK);
        RD_REQ = 1'b1;
        repeat (ncyc) @(negedge CLK);
        RD_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        check("rd_all_popped", sb_q.size(), 0);
        check("rd_end_done", DONE, 0);
        check("rd_end_trig", TRIGGERED, 0);
        check("rd_end_busy", BUSY, 0);
        sb_q.delete();
    endtask

    initial begin
        #2;
        check("rst_one", ONE, 1);
        check("rst_busy", BUSY, 0);
        check("rst_trig", TRIGGERED, 0);
        check("rst_done", DONE, 0);
        check("rst_rd", {RD_LAST, RD_VALID, RD_DATA}, 0);
        @(negedge CLK);
        CLRN = 1'b1;

        // Reads in IDLE are ignored.
        RD_REQ = 1'b1;
        repeat (3) @(negedge CLK);
        RD_REQ = 1'b0;
        check("idle_rd_valid", RD_VALID, 0);

        // 1: rising trigger, pre=4.
        arm(4'd4, 1'b0, 8'h80);
        capture_done(1, 0);
        read_all(1, 20);

        // 2: falling slope on rising ramp never triggers; FORCE does.
        arm(4'd4, 1'b1, 8'h80);
        @(negedge CLK); FORCE = 1'b1;   // in PREFILL: ignored
        @(negedge CLK); FORCE = 1'b0;
        feed(2, 40, 0, 1'b0);
        check("t2_no_trig", TRIGGERED, 0);
        check("t2_busy", BUSY, 1);
        @(negedge CLK); FORCE = 1'b1;
        @(negedge CLK); FORCE = 1'b0;
        feed(2, 1, 0, 1'b0);
        check("t2_forced", TRIGGERED, 1);
        capture_done(2, 0);
        read_all(2, 20);

        // 3: pre=0 (first sample never level-triggers), then pre=15.
        arm(4'd0, 1'b0, 8'h80);
        capture_done(3, 0);
        read_all(3, 20);
        arm(4'd15, 1'b0, 8'h80);
        capture_done(1, 0);
        read_all(4, 20);

        // 4: 50 armed samples, SAMPLE_EN 1-in-3.
        arm(4'd4, 1'b0, 8'h80);
        capture_done(4, 2);
        read_all(5, 20);

        // 5: ARM during POST ignored; RD_REQ held exactly 16 cycles.
        arm(4'd4, 1'b0, 8'h80);
        feed(1, 10, 0, 1'b0);
        @(negedge CLK); ARM = 1'b1; PRE_CNT = 4'd0;
        @(negedge CLK); ARM = 1'b0;
        check("t5_busy", BUSY, 1);
        check("t5_trig", TRIGGERED, 1);
        capture_done(1, 0);
        read_all(1, 16);

        // 6: reset mid-POST, then a normal capture.
        arm(4'd4, 1'b0, 8'h80);
        feed(1, 12, 0, 1'b0);
        #3 CLRN = 1'b0;
        #1;
        check("t6_one", ONE, 1);
        check("t6_busy", BUSY, 0);
        check("t6_trig", TRIGGERED, 0);
        check("t6_done", DONE, 0);
        @(negedge CLK); CLRN = 1'b1;
        arm(4'd4, 1'b0, 8'h80);
        capture_done(1, 0);
        read_all(1, 20);

        // ARM in DONE abandons a partial readout.
        arm(4'd4, 1'b0, 8'h80);
        capture_done(1, 0);
        for (int i = 0; i < 5; i++) sb_q.push_back({1'b0, exp_rec(1, i)});
        @(negedge CLK); RD_REQ = 1'b1;
        repeat (5) @(negedge CLK);
        RD_REQ = 1'b0; ARM = 1'b1; PRE_CNT = 4'd4;
        @(negedge CLK); ARM = 1'b0;
        check("t7_partial_popped", sb_q.size(), 0);
        check("t7_busy", BUSY, 1);
        check("t7_done", DONE, 0);
        k_g = 0;
        capture_done(1, 0);
        read_all(1, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
